// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: circular byte FIFO plus launch sequencer placed in front of
// uart_tx. Bytes from the host write port are queued, then presented one at a
// time on tx_start/tx_data with a one-cycle data setup. The next byte is held
// back until the current frame reports tx_done and a programmable idle gap
// has elapsed.
module uart_tx_feeder #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done
);

  // Gap counter must hold GAP_CYCLES; keep at least one bit when the gap is 0 or 1.
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]    count_reg, count_next;
  logic               overflow_reg;
  logic [DATA_W-1:0]  tx_data_reg;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               wr_accept;
  logic               wr_drop;
  logic               pop;

  // Full/empty are judged on the pre-cycle count, so a pop never frees a slot
  // for a write in the same cycle.
  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign tx_data   = tx_data_reg;
  assign wr_accept = wr_en && !full;
  assign wr_drop   = wr_en && full;
  // The only pop point is the IDLE->LOAD transition.
  assign pop       = (state_reg == S_IDLE) && !empty && !tx_busy;

  // Storage array write port; entries are only ever read behind count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Occupancy bookkeeping: +1 on accepted write, -1 on pop, unchanged on both.
  always_comb begin
    count_next = count_reg;
    case ({wr_accept, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointers, count, sticky overflow and the registered output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        tx_data_reg <= mem[rd_ptr_reg];
      end
      // A dropped write wins over a clear arriving in the same cycle.
      if (wr_drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Launch sequencer state and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  // Next-state and tx_start decode; tx_start is a pure state decode so an
  // asynchronous reset drops it without waiting for a clock edge.
  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    tx_start     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pop) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = S_START;
      end
      S_START: begin
        tx_start = 1'b1;
        if (tx_busy) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (GAP_CYCLES == 0) begin
            state_next = S_IDLE;
          end else begin
            gap_cnt_next = GAP_LOAD;
            state_next   = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_cnt_next = gap_cnt_reg - 1'b1;
        if (gap_cnt_reg == GAP_W'(1)) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small uart_tx stand-in model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_feeder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int GAP    = 4;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              wr_en   = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ovf_clr = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              tx_done;

  // uart_tx stand-in plus bench overrides
  logic model_en   = 1'b0;
  logic model_busy = 1'b0;
  logic model_done = 1'b0;
  logic hold_busy  = 1'b0;
  logic stray_done = 1'b0;
  int   model_cnt  = 0;

  assign tx_busy = model_busy | hold_busy;
  assign tx_done = model_done | stray_done;

  uart_tx_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy one cycle after start is seen, tx_done pulse 10 cycles later.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (!model_en) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (!model_busy) begin
      if (tx_start) begin
        model_busy <= 1'b1;
        model_cnt  <= 10;
      end
    end else if (model_cnt == 1) begin
      model_busy <= 1'b0;
      model_done <= 1'b1;
    end else begin
      model_cnt <= model_cnt - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Launch monitor state, updated on every falling edge the test steps through.
  logic [DATA_W-1:0] got_q[$];
  int rise_cyc   = -1;
  int done_edge  = -1;
  bit prev_start = 1'b0;
  bit gap_chk    = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (tx_done) done_edge = cyc + 1;
    if (tx_start && !prev_start) begin
      got_q.push_back(tx_data);
      rise_cyc = cyc;
      $display("launch: byte 0x%02h at cycle %0d", tx_data, cyc);
      if (gap_chk && done_edge >= 0)
        check_eq("done_to_start_gap", 32'(rise_cyc - done_edge), 32'(GAP + 2));
    end
    prev_start = tx_start;
  endtask

  task automatic wait_launches(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq({nm, "_launch_count"}, 32'(got_q.size()), 32'(n));
  endtask

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] wd;
    logic              clr;
    logic [ADDR_W:0]   cnt;
    logic              fu;
    logic              em;
    logic              ov;
  } vec_t;

  vec_t vecs[13];
  int   w_edge;
  int   k;
  int   n_before;

  initial begin
    // Fill/overflow table, applied with tx_busy forced high so nothing pops.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{we: 1'b1, wd: 8'(i + 1), clr: 1'b0, cnt: 4'(i + 1),
                  fu: (i == 7), em: 1'b0, ov: 1'b0};
    vecs[8]  = '{we: 1'b1, wd: 8'hFF, clr: 1'b0, cnt: 4'd8, fu: 1'b1, em: 1'b0, ov: 1'b1};
    vecs[9]  = '{we: 1'b0, wd: 8'h00, clr: 1'b1, cnt: 4'd8, fu: 1'b1, em: 1'b0, ov: 1'b0};
    vecs[10] = '{we: 1'b1, wd: 8'hEE, clr: 1'b1, cnt: 4'd8, fu: 1'b1, em: 1'b0, ov: 1'b1};
    vecs[11] = '{we: 1'b0, wd: 8'h00, clr: 1'b1, cnt: 4'd8, fu: 1'b1, em: 1'b0, ov: 1'b0};
    vecs[12] = '{we: 1'b0, wd: 8'h00, clr: 1'b0, cnt: 4'd8, fu: 1'b1, em: 1'b0, ov: 1'b0};

    // Reset state
    repeat (3) tick();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single byte: latency, busy handshake, gap
    model_en = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'hAA;
    w_edge   = cyc + 1;
    tick();
    wr_en = 1'b0;
    wait_launches(1, 20, "single");
    check_eq("start_latency", 32'(rise_cyc - w_edge), 32'd2);
    check_eq("single_data", 32'(got_q[0]), 32'hAA);
    k = 0;
    while (!tx_busy && k < 20) begin tick(); k++; end
    check_eq("busy_seen", 32'(tx_busy), 32'd1);
    check_eq("start_held_until_busy_sampled", 32'(tx_start), 32'd1);
    tick();
    check_eq("start_falls_after_busy", 32'(tx_start), 32'd0);
    check_eq("count_after_pop", 32'(count), 32'd0);
    k = 0;
    while (!tx_done && k < 30) begin tick(); k++; end
    check_eq("done_seen", 32'(tx_done), 32'd1);
    for (int i = 0; i < GAP; i++) begin
      tick();
      check_eq("gap_empty", 32'(empty), 32'd1);
      check_eq("gap_no_start", 32'(tx_start), 32'd0);
    end

    // Burst fill, overflow and clear priority (table driven)
    hold_busy = 1'b1;
    tick();
    got_q.delete();
    for (int i = 0; i < 13; i++) begin
      wr_en   = vecs[i].we;
      wr_data = vecs[i].wd;
      ovf_clr = vecs[i].clr;
      tick();
      $display("vec %0d: we=%0d wd=0x%02h clr=%0d -> count=%0d full=%0d empty=%0d ovf=%0d",
               i, vecs[i].we, vecs[i].wd, vecs[i].clr, count, full, empty, overflow);
      check_eq("vec_count", 32'(count), 32'(vecs[i].cnt));
      check_eq("vec_full", 32'(full), 32'(vecs[i].fu));
      check_eq("vec_empty", 32'(empty), 32'(vecs[i].em));
      check_eq("vec_overflow", 32'(overflow), 32'(vecs[i].ov));
    end
    wr_en   = 1'b0;
    ovf_clr = 1'b0;

    // Drain the burst and measure the inter-frame gap
    done_edge = -1;
    gap_chk   = 1'b1;
    hold_busy = 1'b0;
    wait_launches(8, 400, "burst");
    gap_chk = 1'b0;
    for (int i = 0; i < 8; i++)
      check_eq("burst_order", 32'(got_q[i]), 32'(i + 1));
    repeat (30) tick();

    // Wrap-around: writes interleaved with frames
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick();
      wr_en = 1'b0;
      repeat (9) tick();
    end
    wait_launches(12, 300, "wrap");
    for (int i = 0; i < 12; i++)
      check_eq("wrap_order", 32'(got_q[i]), 32'(8'h30 + i));
    repeat (30) tick();
    check_eq("wrap_final_count", 32'(count), 32'd0);
    check_eq("wrap_no_overflow", 32'(overflow), 32'd0);

    // tx_busy held low: START must persist with no further pop
    model_en = 1'b0;
    got_q.delete();
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_data = 8'h6B;
    tick();
    wr_en = 1'b0;
    wait_launches(1, 20, "hold");
    for (int i = 0; i < 50; i++) begin
      tick();
      check_eq("hold_start_data_count", 32'({tx_start, tx_data, count}),
               32'({1'b1, 8'h5A, 4'd1}));
    end

    // Reach WAIT with three bytes queued, then reset asynchronously
    model_en = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'h7C;
    tick();
    wr_data = 8'h8D;
    tick();
    wr_en = 1'b0;
    tick();
    check_eq("pre_reset_count", 32'(count), 32'd3);
    check_eq("pre_reset_in_wait", 32'({tx_start, tx_busy}), 32'({1'b0, 1'b1}));
    rst_n    = 1'b0;
    model_en = 1'b0;
    #1;
    check_eq("async_rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("async_rst_count", 32'(count), 32'd0);
    check_eq("async_rst_empty", 32'(empty), 32'd1);
    check_eq("async_rst_tx_data", 32'(tx_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_before   = got_q.size();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("stray_done_ignored", 32'({tx_start, count, empty}),
               32'({1'b0, 4'd0, 1'b1}));
    end
    check_eq("stray_done_no_launch", 32'(got_q.size()), 32'(n_before));

    // Normal operation after reset
    model_en = 1'b1;
    got_q.delete();
    wr_en   = 1'b1;
    wr_data = 8'h9E;
    tick();
    wr_en = 1'b0;
    wait_launches(1, 20, "post_reset");
    check_eq("post_reset_data", 32'(got_q[0]), 32'h9E);
    repeat (30) tick();
    check_eq("post_reset_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and launch sequencer that sits directly upstream of uart_tx.
- Accepts bytes from a host-side write port into a circular FIFO.
- Presents one byte at a time on uart_tx's start/tx_parallel_data inputs, and waits for busy/tx_done before releasing the next byte.
- Enforces a programmable idle gap between frames on the serial line.

Parameters:
- DATA_W, 8, byte width; must match the uart_tx parallel input width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH).
- GAP_CYCLES, 4, idle clk cycles inserted after each tx_done before the next launch; 0 means back-to-back.

Ports:
- clk  input  1  single block clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  host write strobe; one byte per cycle while high.
- wr_data  input  DATA_W  host byte, sampled when wr_en=1.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- count  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was dropped.
- ovf_clr  input  1  clears overflow; set has priority over clear in the same cycle.
- tx_start  output  1  connects to uart_tx start.
- tx_data  output  DATA_W  connects to uart_tx tx_parallel_data; held stable while tx_start=1.
- tx_busy  input  1  from uart_tx busy.
- tx_done  input  1  from uart_tx tx_done, a single-cycle pulse at end of frame.

Behaviour:
- Reset (async assert, sync-safe release):
  - rd_ptr=0, wr_ptr=0, count=0, so empty=1 and full=0.
  - overflow=0, tx_start=0, tx_data=0, gap counter=0, state=IDLE.
  - Reset mid-frame discards the FIFO contents and the in-flight byte, and drops tx_start low immediately. The block does not track the remainder of an interrupted uart_tx frame.
- Write side:
  - A write is accepted iff wr_en=1 and count<DEPTH at the start of the cycle.
  - Accepting a write stores wr_data at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
  - wr_en=1 with count==DEPTH: byte dropped, overflow set on the next edge, pointers unchanged.
  - A pop in the same cycle does not make room for a write when full. Full is judged on the pre-cycle count.
- Pop:
  - Happens only in the IDLE->LOAD transition.
  - Copies mem[rd_ptr] into the tx_data register and increments rd_ptr, which wraps.
  - Simultaneous accepted write and pop: count unchanged.
  - A write into an empty FIFO becomes visible to IDLE on the following cycle. Minimum latency from write to tx_start=1 is 2 cycles.
- FSM:
  - IDLE: tx_start=0. If !empty and tx_busy=0, pop and go to LOAD.
  - LOAD: tx_data stable, tx_start=0. Next cycle go to START. This gives uart_tx one cycle of data setup.
  - START: tx_start=1 and tx_data held. When tx_busy=1 is sampled, go to WAIT, and tx_start=0 from the next cycle. Remain in START indefinitely while tx_busy=0.
  - WAIT: tx_start=0. On tx_done=1, load the gap counter with GAP_CYCLES and go to GAP. If GAP_CYCLES==0, go directly to IDLE.
  - GAP: decrement the counter each cycle; at 1, go to IDLE. Exactly GAP_CYCLES cycles are spent in GAP.
- tx_data keeps its last byte after the frame completes and changes only on pop.
- A tx_done pulse outside WAIT is ignored.
- Writes and ovf_clr operate in every state.

Test Plan:
- Reset, write 8'hAA once, uart_tx model asserts busy 1 cycle after start and pulses tx_done 10 cycles later:
  - tx_start rises 2 cycles after the write, with tx_data=8'hAA.
  - tx_start falls the cycle after busy is seen.
  - count returns to 0.
  - empty=1 throughout GAP.
- Burst-write 8'h01..8'h08 on consecutive cycles: full=1 after the 8th write, and bytes appear on tx_data in order 01..08. The gap between tx_done and the next tx_start is exactly GAP_CYCLES+2 cycles (GAP, then IDLE->LOAD->START).
- With the FIFO full, write 8'hFF: byte dropped, overflow=1, count stays 8. Pulse ovf_clr: overflow=0. Assert ovf_clr together with another dropped write: overflow stays 1.
- Wrap-around: run 12 writes interleaved with frames so that rd_ptr and wr_ptr both wrap. The output sequence matches the input sequence exactly, with no duplicate or skipped byte.
- Hold tx_busy=0 for 50 cycles after the launch: tx_start stays 1 and tx_data stays stable for all 50 cycles, with no pop.
- Assert rst_n=0 while in WAIT with 3 bytes queued: tx_start=0, count=0 and empty=1 immediately, before any clock edge. After release, a stray tx_done causes no action.
